// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared types, channel ids and constants for the MAC scheduler.
package mac_sched_pkg;
    typedef enum logic [1:0] {IDLE, TERM1, TERM2} state_t;
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;
    localparam logic signed [7:0] K1_DEF = 8'sd3;
    localparam logic signed [7:0] K2_DEF = 8'sd5;
    function automatic logic signed [15:0] sext16(input logic signed [7:0] v);
        return {{8{v[7]}}, v};
    endfunction
endpackage

// File: rtl/shared_mac_unit.sv
// shared_mac_unit: combinational signed 8x8 multiply feeding a 16-bit wrapping adder.
module shared_mac_unit (
    input  logic signed [7:0]  op1,
    input  logic signed [7:0]  op2,
    input  logic signed [15:0] addend,
    output logic signed [15:0] sum
);
    logic signed [15:0] prod;
    assign prod = op1 * op2;
    assign sum  = prod + addend;
endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: round-robin sequencer sharing one MAC between altitude (A) and battery (B) requests.
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter logic signed [7:0] K1    = K1_DEF,
    parameter logic signed [7:0] K2    = K2_DEF,
    parameter int                CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [7:0]        a_x1,
    input  logic [7:0]        a_x2,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [7:0]        b_v,
    input  logic [7:0]        b_t,
    input  logic [7:0]        b_c,
    output logic [15:0]       a_res,
    output logic              a_res_valid,
    output logic [15:0]       b_res,
    output logic              b_res_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  a_done_cnt,
    output logic [CNT_W-1:0]  b_done_cnt
);
    state_t state, state_nx;
    logic chan, last_grant, hs, done;
    logic signed [7:0] r1, r2, r3, m_op1, m_op2;
    logic signed [15:0] acc, m_add, m_sum;

    shared_mac_unit u_mac (.op1(m_op1), .op2(m_op2), .addend(m_add), .sum(m_sum));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (hs ? TERM1 : IDLE) :
                   state == TERM1 ? TERM2 : IDLE;
    end

    // B wins only when A is absent or A was served last; the c offset rides the multiplier as c*1.
    always_comb begin
        b_ready = state == IDLE && b_valid && (!a_valid || last_grant == CH_A);
        a_ready = state == IDLE && a_valid && !b_ready;
        hs      = a_ready || b_ready;
        busy    = state != IDLE;
        done    = state == TERM2;
        m_op1   = state == TERM1 ? r1 : (chan == CH_A ? r2 : r3);
        m_op2   = state == TERM1 ? (chan == CH_A ? K1 : r2) : (chan == CH_A ? K2 : 8'sd1);
        m_add   = state == TERM1 ? sext16(8'sd0) : acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan        <= CH_A;
            last_grant  <= CH_B;
            r1          <= '0;
            r2          <= '0;
            r3          <= '0;
            acc         <= '0;
            a_res       <= '0;
            b_res       <= '0;
            a_res_valid <= 1'b0;
            b_res_valid <= 1'b0;
            a_done_cnt  <= '0;
            b_done_cnt  <= '0;
        end else begin
            a_res_valid <= done && chan == CH_A;
            b_res_valid <= done && chan == CH_B;
            if (hs) begin
                chan       <= b_ready;
                last_grant <= b_ready;
                r1         <= b_ready ? b_v : a_x1;
                r2         <= b_ready ? b_t : a_x2;
                r3         <= b_c;
            end
            if (state == TERM1) acc <= m_sum;
            if (done && chan == CH_A) begin
                a_res      <= m_sum;
                a_done_cnt <= a_done_cnt + CNT_W'(1);
            end
            if (done && chan == CH_B) begin
                b_res      <= m_sum;
                b_done_cnt <= b_done_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mac_scheduler.sv
// tb_mac_scheduler: directed stimulus with a transaction-level reference model checked every cycle.
module tb_mac_scheduler;
    logic clk = 1'b0, rst = 1'b0;
    logic a_valid, b_valid;
    logic signed [7:0] a_x1, a_x2, b_v, b_t, b_c;
    logic a_ready, b_ready, a_res_valid, b_res_valid, busy;
    logic [15:0] a_res, b_res, a_done_cnt, b_done_cnt;

    always #5 clk = ~clk;

    mac_scheduler dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_x1(a_x1), .a_x2(a_x2),
        .b_valid(b_valid), .b_ready(b_ready), .b_v(b_v), .b_t(b_t), .b_c(b_c),
        .a_res(a_res), .a_res_valid(a_res_valid), .b_res(b_res), .b_res_valid(b_res_valid),
        .busy(busy), .a_done_cnt(a_done_cnt), .b_done_cnt(b_done_cnt)
    );

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: phase counts edges remaining until the pending result lands (0 = idle).
    int m_phase;
    logic m_last, m_ch, e_arv, e_brv;
    logic [15:0] m_val, e_ares, e_bres, e_acnt, e_bcnt;
    logic e_ar, e_br;

    assign e_ar = m_phase == 0 && a_valid && !(b_valid && m_last == 1'b0);
    assign e_br = m_phase == 0 && b_valid && !(a_valid && m_last == 1'b1);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_ch    <= 1'b0;
            m_val   <= '0;
            e_ares  <= '0;
            e_bres  <= '0;
            e_arv   <= 1'b0;
            e_brv   <= 1'b0;
            e_acnt  <= '0;
            e_bcnt  <= '0;
        end else begin
            e_arv <= 1'b0;
            e_brv <= 1'b0;
            if (m_phase == 2) m_phase <= 1;
            else if (m_phase == 1) begin
                m_phase <= 0;
                if (!m_ch) begin e_ares <= m_val; e_arv <= 1'b1; e_acnt <= e_acnt + 16'd1; end
                else       begin e_bres <= m_val; e_brv <= 1'b1; e_bcnt <= e_bcnt + 16'd1; end
            end else if (e_ar || e_br) begin
                m_phase <= 2;
                m_ch    <= e_br;
                m_last  <= e_br;
                m_val   <= e_br ? 16'(int'(b_v) * int'(b_t) + int'(b_c))
                                : 16'(3 * int'(a_x1) + 5 * int'(a_x2));
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("a_ready", a_ready, e_ar);
            check("b_ready", b_ready, e_br);
            check("ready_excl", a_ready & b_ready, 0);
            check("busy", busy, m_phase != 0);
            check("a_res", a_res, e_ares);
            check("a_res_valid", a_res_valid, e_arv);
            check("b_res", b_res, e_bres);
            check("b_res_valid", b_res_valid, e_brv);
            check("a_done_cnt", a_done_cnt, e_acnt);
            check("b_done_cnt", b_done_cnt, e_bcnt);
        end
    end

    initial begin
        a_valid = 0; b_valid = 0;
        a_x1 = 0; a_x2 = 0; b_v = 0; b_t = 0; b_c = 0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_a_res", a_res, 0);
        check("rst_b_res", b_res, 0);
        check("rst_cnt", {a_done_cnt, b_done_cnt}, 0);
        rst = 1;

        a_x1 = 10; a_x2 = 4; a_valid = 1;
        tick(1); a_valid = 0;
        tick(2);
        check("A_only_res", a_res, 16'h0032);
        check("A_only_pulse", a_res_valid, 1);
        check("A_only_b_pulse", b_res_valid, 0);
        check("A_only_cnt", a_done_cnt, 1);
        tick(1);
        check("A_only_pulse_end", a_res_valid, 0);

        b_v = -3; b_t = 7; b_c = -5; b_valid = 1;
        tick(1); b_valid = 0; b_v = 99; b_t = 99; b_c = 99;
        check("B_busy1", busy, 1);
        tick(1);
        check("B_busy2", busy, 1);
        tick(1);
        check("B_busy_off", busy, 0);
        check("B_res", b_res, 16'hFFE6);
        check("B_cnt", b_done_cnt, 1);
        check("B_a_untouched", a_res, 16'h0032);

        b_v = -128; b_t = -128; b_c = 127; b_valid = 1;
        tick(1); b_valid = 0; tick(2);
        check("B_extreme", b_res, 16'h407F);
        a_x1 = -128; a_x2 = -128; a_valid = 1;
        tick(1); a_valid = 0; tick(2);
        check("A_extreme", a_res, 16'hFC00);
        check("A_extreme_cnt", a_done_cnt, 2);

        rst = 0;
        tick(1);
        a_x1 = 1; a_x2 = 1; b_v = 2; b_t = 3; b_c = 1;
        a_valid = 1; b_valid = 1; rst = 1;
        tick(12);
        check("cont_a_res", a_res, 16'd8);
        check("cont_b_res", b_res, 16'd7);
        check("cont_cnts", {a_done_cnt, b_done_cnt}, {16'd2, 16'd2});
        check("cont_last_pulse", b_res_valid, 1);
        a_valid = 0; b_valid = 0;
        tick(2);

        b_v = 5; b_t = 5; b_c = 0; b_valid = 1;
        tick(1); b_valid = 0;
        #2 rst = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res", {a_res, b_res}, 0);
        check("midrst_cnts", {a_done_cnt, b_done_cnt}, 0);
        tick(2);
        check("midrst_no_pulse", {a_res_valid, b_res_valid}, 0);
        a_valid = 1; b_valid = 1; rst = 1;
        #1;
        check("post_rst_a_ready", a_ready, 1);
        check("post_rst_b_ready", b_ready, 0);
        tick(1); a_valid = 0; b_valid = 0;
        tick(4);
        check("post_rst_a_res", a_res, 16'd8);
        check("post_rst_cnts", {a_done_cnt, b_done_cnt}, {16'd1, 16'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mac_scheduler.md
Name: mac_scheduler

Overview:
Sequencer and arbiter for the shared signed 8x8 multiplier and 16-bit adder in the flight-telemetry math path. Two requesters share the unit: altitude correction (3*x1 + 5*x2) on channel A and battery estimation (v*t + c) on channel B. Each request is accepted over a valid/ready handshake and arbitrated round-robin. The block runs two term cycles per request and returns a tagged 16-bit result with a one-cycle valid pulse.

Parameters:
K1, 3, signed 8-bit altitude coefficient for x1
K2, 5, signed 8-bit altitude coefficient for x2
CNT_W, 16, width of the per-channel completion counters

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
a_valid  in  1  channel A request valid
a_ready  out  1  channel A accepted this cycle
a_x1  in  8  signed altitude operand x1
a_x2  in  8  signed altitude operand x2
b_valid  in  1  channel B request valid
b_ready  out  1  channel B accepted this cycle
b_v  in  8  signed battery operand v
b_t  in  8  signed battery operand t
b_c  in  8  signed battery offset c
a_res  out  16  last channel A result, signed
a_res_valid  out  1  one-cycle pulse when a_res is updated
b_res  out  16  last channel B result, signed
b_res_valid  out  1  one-cycle pulse when b_res is updated
busy  out  1  high whenever state is not IDLE
a_done_cnt  out  CNT_W  completed A requests; wraps at 2^CNT_W
b_done_cnt  out  CNT_W  completed B requests; wraps at 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; all results, valids, counters and operand registers 0.
  - last_grant = B, so A wins the first contention.
- FSM states: IDLE, TERM1, TERM2.
- IDLE:
  - Grant is combinational. If only one valid is high, that channel wins. If both are high, the channel not equal to last_grant wins.
  - a_ready/b_ready = (state==IDLE) & winning channel; never both high.
  - Handshake edge E0 (valid & ready): capture the granted channel's operands and channel id, set last_grant, go to TERM1.
  - With no valid, stay in IDLE.
- TERM1 (edge E1):
  - acc <= sext16(op1*op2). A: x1*K1. B: v*t.
  - Go to TERM2.
- TERM2 (edge E2):
  - A: result = acc + sext16(x2*K2). B: result = acc + sext16(c).
  - Write result to the tagged channel's res register and pulse that channel's res_valid for exactly one cycle (the cycle after E2).
  - Increment that channel's counter. Go to IDLE.
- Latency: result visible in the cycle following E2, two edges after the handshake. The next handshake is possible at E3 at the earliest, giving 1 request per 3 cycles.
- Arithmetic:
  - All multiplies are signed 8x8 into 16 bits.
  - The adder is 16-bit two's complement; overflow wraps, with no saturation.
  - With default K values, all results fit.
- Operands are sampled only at the handshake; later input changes have no effect.
- A requester may drop valid before being granted; no penalty.
- The non-target channel's res and res_valid are untouched while the other channel is being served.
- res registers hold their value until overwritten.
- Reset mid-operation:
  - Abort immediately; no res_valid pulse; counters clear.
  - After release, the first contention grants A.

Decomposition:
- Shared package mac_sched_pkg:
  - state enum (IDLE, TERM1, TERM2)
  - channel id constants (CH_A=0, CH_B=1)
  - default K1/K2 values
  - 16-bit sign-extension helper function
- Sub-module shared_mac_unit: combinational signed 8x8 multiply plus 16-bit add, with ports op1, op2, addend, and sum. The scheduler drives it with operands muxed per state and channel.

Test Plan:
- A only, x1=10, x2=4 -> a_ready at E0; a_res=0x0032 (50); a_res_valid pulse in the cycle after E2; b_res_valid stays 0; a_done_cnt=1.
- B only, v=0xFD (-3), t=7, c=0xFB (-5) -> b_res=0xFFE6 (-26); b_done_cnt=1.
- a_valid and b_valid held high from reset release (x1=1, x2=1, v=2, t=3, c=1) -> grant order A,B,A,B; results alternate 8 and 7; handshakes spaced 3 cycles; ready never both high.
- Extremes:
  - v=-128, t=-128, c=127 -> b_res=0x407F (16511).
  - x1=-128, x2=-128 -> a_res=0xFC00 (-1024).
- Pull rst low while in TERM1 of a B request -> all outputs 0 asynchronously with no pulse; after release with both valid, A is granted first.
- Change b_v/b_t/b_c on the cycle after the handshake -> result reflects the captured values only; busy high for exactly 2 cycles per request.
